polaris_bus_sequencer: RTL and testbench

Sequences Polaris CPU memory requests onto the 16-bit external bus. Arbitrates between the instruction-fetch port and the load/store port. Splits each 8/16/32/64-bit request into 16-bit beats paced by `ack_i`, and assembles read data. Sits between the Polaris core pipeline and the external memory bus.

---
 rtl/polaris_bus_pkg.sv | 24 ++
 rtl/polaris_bus_sequencer_if.sv | 47 ++++
 rtl/polaris_bus_arbiter.sv | 26 ++
 rtl/polaris_bus_sequencer.sv | 112 +++++++++++
 tb/tb_polaris_bus_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/polaris_bus_pkg.sv
// Shared types for the Polaris external-bus sequencer: size codes, FSM states, beat count.
package polaris_bus_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic [2:0] beats(input logic [1:0] size);
        case (size)
            SZ_WORD:  beats = 3'd2;
            SZ_DWORD: beats = 3'd4;
            default:  beats = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/polaris_bus_sequencer_if.sv
// Core-side request ports plus the 16-bit external bus; master = the sequencer, slave = core/memory side.
interface polaris_bus_sequencer_if #(parameter int ADR_W = 64);

    logic             f_req_i;
    logic [ADR_W-1:0] f_adr_i;
    logic [1:0]       f_size_i;
    logic             f_ack_o;
    logic             f_err_o;
    logic [63:0]      f_dat_o;

    logic             d_req_i;
    logic [ADR_W-1:0] d_adr_i;
    logic [1:0]       d_size_i;
    logic             d_we_i;
    logic [63:0]      d_dat_i;
    logic             d_ack_o;
    logic             d_err_o;
    logic [63:0]      d_dat_o;

    logic             cyc_o;
    logic [ADR_W-1:0] adr_o;
    logic [1:0]       size_o;
    logic             we_o;
    logic             vpa_o;
    logic [15:0]      dat_o;
    logic [15:0]      dat_i;
    logic             ack_i;

    modport master (
        input  f_req_i, f_adr_i, f_size_i,
        output f_ack_o, f_err_o, f_dat_o,
        input  d_req_i, d_adr_i, d_size_i, d_we_i, d_dat_i,
        output d_ack_o, d_err_o, d_dat_o,
        output cyc_o, adr_o, size_o, we_o, vpa_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        output f_req_i, f_adr_i, f_size_i,
        input  f_ack_o, f_err_o, f_dat_o,
        output d_req_i, d_adr_i, d_size_i, d_we_i, d_dat_i,
        input  d_ack_o, d_err_o, d_dat_o,
        input  cyc_o, adr_o, size_o, we_o, vpa_o, dat_o,
        output dat_i, ack_i
    );

endinterface

// File: rtl/polaris_bus_arbiter.sv
// Two-way round-robin between fetch and data; combinational grant, last-grant flop updates only on a grant.
module polaris_bus_arbiter (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_en,
    input  logic i_f_req,
    input  logic i_d_req,
    output logic o_gnt_vld,
    output logic o_gnt_fetch
);

    logic r_last_fetch;

    // On a tie the port not served last wins; reset value favours fetch first.
    assign o_gnt_vld   = i_en & (i_f_req | i_d_req);
    assign o_gnt_fetch = i_f_req & (~i_d_req | ~r_last_fetch);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last_fetch <= 1'b0;
        end else if (o_gnt_vld) begin
            r_last_fetch <= o_gnt_fetch;
        end
    end

endmodule

// File: rtl/polaris_bus_sequencer.sv
// Splits fetch/load/store requests into ack_i-paced 16-bit beats and assembles read data.
// Cost with no wait states: 1 IDLE + N beats + 1 DONE cycle; misaligned requests take IDLE + ERR.
module polaris_bus_sequencer
    import polaris_bus_pkg::*;
#(
    parameter int ADR_W = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    polaris_bus_sequencer_if.master bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUS  = ST_BUS;
    localparam logic [1:0] S_DONE = ST_DONE;
    localparam logic [1:0] S_ERR  = ST_ERR;

    logic [1:0]       r_state;
    logic [1:0]       r_cnt;
    logic [ADR_W-1:0] r_adr;
    logic [1:0]       r_size;
    logic             r_we;
    logic             r_fetch;
    logic [63:0]      r_wdat;
    logic [63:0]      r_f_dat;
    logic [63:0]      r_d_dat;

    logic             w_gnt_vld;
    logic             w_gnt_fetch;
    logic [ADR_W-1:0] w_sel_adr;
    logic [1:0]       w_sel_size;
    logic             w_misalign;
    logic             w_cyc;
    logic             w_last;
    logic [15:0]      w_rd_word;
    logic [15:0]      w_beat_dat;

    polaris_bus_arbiter u_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_en        (r_state == S_IDLE),
        .i_f_req     (bus.f_req_i),
        .i_d_req     (bus.d_req_i),
        .o_gnt_vld   (w_gnt_vld),
        .o_gnt_fetch (w_gnt_fetch)
    );

    assign w_sel_adr  = w_gnt_fetch ? bus.f_adr_i  : bus.d_adr_i;
    assign w_sel_size = w_gnt_fetch ? bus.f_size_i : bus.d_size_i;
    assign w_misalign = (w_sel_size != SZ_BYTE) & w_sel_adr[0];
    assign w_cyc      = (r_state == S_BUS);
    assign w_last     = ({1'b0, r_cnt} == (beats(r_size) - 3'd1));
    assign w_rd_word  = (r_size == SZ_BYTE) ? {8'h00, bus.dat_i[7:0]} : bus.dat_i;
    // A byte store is replicated on both lanes so either byte strobe sees it.
    assign w_beat_dat = (r_size == SZ_BYTE) ? {2{r_wdat[7:0]}} : r_wdat[{r_cnt, 4'b0000} +: 16];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_adr   <= '0;
            r_size  <= SZ_BYTE;
            r_we    <= 1'b0;
            r_fetch <= 1'b0;
            r_wdat  <= 64'd0;
            r_f_dat <= 64'd0;
            r_d_dat <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_adr   <= w_sel_adr;
                        r_size  <= w_sel_size;
                        r_we    <= ~w_gnt_fetch & bus.d_we_i;
                        r_fetch <= w_gnt_fetch;
                        r_wdat  <= bus.d_dat_i;
                        r_cnt   <= 2'd0;
                        if (w_gnt_fetch) r_f_dat <= 64'd0;
                        else             r_d_dat <= 64'd0;
                        r_state <= w_misalign ? S_ERR : S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus.ack_i) begin
                        if (!r_we) begin
                            if (r_fetch) r_f_dat[{r_cnt, 4'b0000} +: 16] <= w_rd_word;
                            else         r_d_dat[{r_cnt, 4'b0000} +: 16] <= w_rd_word;
                        end
                        r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
                        if (w_last) r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cyc_o   = w_cyc;
    assign bus.adr_o   = r_adr + ADR_W'({r_cnt, 1'b0});
    assign bus.size_o  = r_size;
    assign bus.we_o    = w_cyc & r_we;
    assign bus.vpa_o   = w_cyc & r_fetch;
    assign bus.dat_o   = (w_cyc & r_we) ? w_beat_dat : 16'h0000;

    assign bus.f_ack_o = (r_state == S_DONE) &  r_fetch;
    assign bus.d_ack_o = (r_state == S_DONE) & ~r_fetch;
    assign bus.f_err_o = (r_state == S_ERR)  &  r_fetch;
    assign bus.d_err_o = (r_state == S_ERR)  & ~r_fetch;
    assign bus.f_dat_o = r_f_dat;
    assign bus.d_dat_o = r_d_dat;

endmodule

// File: tb/tb_polaris_bus_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats/acks/errs with their cycle numbers, a negedge monitor pops and compares.
module tb_polaris_bus_sequencer;

    localparam int K_BEAT = 0;
    localparam int K_FACK = 1;
    localparam int K_DACK = 2;
    localparam int K_FERR = 3;
    localparam int K_DERR = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] adr;
        logic [1:0]  size;
        logic        we;
        logic        vpa;
        logic [15:0] dat;
        logic [63:0] rdat;
        logic        chk_rdat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i;
    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    bit          mon_en = 1'b0;
    bit          wait_mode = 1'b0;
    bit          waited = 1'b0;
    logic [15:0] rd_tab [4];

    polaris_bus_sequencer_if #(.ADR_W(64)) bus ();

    polaris_bus_sequencer #(.ADR_W(64)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    assign bus.dat_i = rd_tab[bus.adr_o[2:1]];

    // Memory side: ack every cycle, or in wait mode insert one wait state per beat.
    always @(posedge clk) begin
        #1;
        if (!wait_mode) begin
            bus.ack_i = 1'b1;
        end else if (bus.cyc_o) begin
            bus.ack_i = waited;
            waited    = !waited;
        end else begin
            bus.ack_i = 1'b0;
            waited    = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic void push(input int kind, input int cyc, input logic [63:0] adr,
                                 input logic [1:0] size, input logic we, input logic vpa,
                                 input logic [15:0] dat, input logic [63:0] rdat, input logic chk_rdat);
        exp_t e;
        e.kind = kind; e.cyc = cyc; e.adr = adr; e.size = size; e.we = we;
        e.vpa = vpa; e.dat = dat; e.rdat = rdat; e.chk_rdat = chk_rdat;
        q.push_back(e);
    endfunction

    task automatic pop_cmp(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_event: got kind %0d, expected nothing (cycle %0d)", kind, cyc_n);
            return;
        end
        e = q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        chk("event_cycle", 64'(cyc_n), 64'(e.cyc));
        if (kind == K_BEAT) begin
            chk("adr_o", bus.adr_o, e.adr);
            chk("size_o", 64'(bus.size_o), 64'(e.size));
            chk("we_o", 64'(bus.we_o), 64'(e.we));
            chk("vpa_o", 64'(bus.vpa_o), 64'(e.vpa));
            chk("dat_o", 64'(bus.dat_o), 64'(e.dat));
        end else if (kind == K_FACK && e.chk_rdat) begin
            chk("f_dat_o", bus.f_dat_o, e.rdat);
        end else if (kind == K_DACK && e.chk_rdat) begin
            chk("d_dat_o", bus.d_dat_o, e.rdat);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cyc_o)   pop_cmp(K_BEAT);
            if (bus.f_ack_o) pop_cmp(K_FACK);
            if (bus.d_ack_o) pop_cmp(K_DACK);
            if (bus.f_err_o) pop_cmp(K_FERR);
            if (bus.d_err_o) pop_cmp(K_DERR);
        end
    end

    // One request on one port; expected beats and the completion are queued with absolute cycle numbers.
    task automatic xfer(input logic fetch, input logic [63:0] adr, input logic [1:0] size,
                        input logic we, input logic [63:0] wdat, input logic [63:0] exp_rdat,
                        input logic exp_err);
        int          n0, nb, step;
        logic [15:0] bd;
        bit          done;
        @(posedge clk);
        #1;
        if (fetch) begin
            bus.f_req_i = 1'b1; bus.f_adr_i = adr; bus.f_size_i = size;
        end else begin
            bus.d_req_i = 1'b1; bus.d_adr_i = adr; bus.d_size_i = size;
            bus.d_we_i = we; bus.d_dat_i = wdat;
        end
        n0   = cyc_n;
        step = wait_mode ? 2 : 1;
        nb   = (size == 2'd3) ? 4 : (size == 2'd2) ? 2 : 1;
        if (exp_err) begin
            push(fetch ? K_FERR : K_DERR, n0 + 1, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            for (int k = 0; k < nb; k++) begin
                if (!we)             bd = 16'h0000;
                else if (size == 0)  bd = {2{wdat[7:0]}};
                else                 bd = wdat[16*k +: 16];
                for (int s = 0; s < step; s++)
                    push(K_BEAT, n0 + 1 + k*step + s, adr + 64'(2*k), size, we, fetch, bd, 0, 0);
            end
            push(fetch ? K_FACK : K_DACK, n0 + 1 + nb*step, 0, 0, 0, 0, 0, exp_rdat, !we);
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = fetch ? (bus.f_ack_o | bus.f_err_o) : (bus.d_ack_o | bus.d_err_o);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: got no ack/err, expected completion for adr %h", adr);
        end
        @(posedge clk);
        #1;
        bus.f_req_i = 1'b0;
        bus.d_req_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n0;
        reset_i      = 1'b1;
        bus.f_req_i  = 1'b0; bus.f_adr_i = '0; bus.f_size_i = 2'd0;
        bus.d_req_i  = 1'b0; bus.d_adr_i = '0; bus.d_size_i = 2'd0;
        bus.d_we_i   = 1'b0; bus.d_dat_i = 64'd0;
        rd_tab       = '{16'h0, 16'h0, 16'h0, 16'h0};
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("reset_cyc_o", 64'(bus.cyc_o), 64'd0);
        chk("reset_adr_o", bus.adr_o, 64'd0);
        chk("reset_vpa_o", 64'(bus.vpa_o), 64'd0);
        chk("reset_we_o", 64'(bus.we_o), 64'd0);
        chk("reset_acks", 64'({bus.f_ack_o, bus.d_ack_o, bus.f_err_o, bus.d_err_o}), 64'd0);
        chk("reset_dat_o", 64'(bus.dat_o), 64'd0);
        chk("reset_f_dat_o", bus.f_dat_o, 64'd0);
        chk("reset_d_dat_o", bus.d_dat_o, 64'd0);
        mon_en = 1'b1;

        // Word fetch at the top of the address space.
        rd_tab[0] = 16'h0013; rd_tab[1] = 16'h0000;
        xfer(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 2'd2, 1'b0, 64'd0, 64'h0000_0000_0000_0013, 1'b0);
        drain();

        // Dword store, one wait state per beat.
        wait_mode = 1'b1;
        xfer(1'b0, 64'h1000, 2'd3, 1'b1, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        drain();
        wait_mode = 1'b0;

        // Byte load at an odd address, byte store replicated.
        rd_tab[0] = 16'hABCD;
        xfer(1'b0, 64'h2001, 2'd0, 1'b0, 64'd0, 64'h0000_0000_0000_00CD, 1'b0);
        xfer(1'b0, 64'h0041, 2'd0, 1'b1, 64'h0000_0000_0000_335A, 64'd0, 1'b0);
        drain();

        // Misaligned half (data) and word (fetch).
        xfer(1'b0, 64'h0003, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1);
        xfer(1'b1, 64'h0011, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1);
        drain();

        // Contention: last grant was fetch, so data wins the first tie here.
        rd_tab[1] = 16'h2222; rd_tab[2] = 16'h3333;
        @(posedge clk);
        #1;
        bus.f_req_i = 1'b1; bus.f_adr_i = 64'h12; bus.f_size_i = 2'd1;
        bus.d_req_i = 1'b1; bus.d_adr_i = 64'h24; bus.d_size_i = 2'd1; bus.d_we_i = 1'b0;
        n0 = cyc_n;
        for (int r = 0; r < 2; r++) begin
            push(K_BEAT, n0 + 1 + 6*r, 64'h24, 2'd1, 1'b0, 1'b0, 16'h0, 0, 0);
            push(K_DACK, n0 + 2 + 6*r, 0, 0, 0, 0, 0, 64'h3333, 1'b1);
            push(K_BEAT, n0 + 4 + 6*r, 64'h12, 2'd1, 1'b0, 1'b1, 16'h0, 0, 0);
            push(K_FACK, n0 + 5 + 6*r, 0, 0, 0, 0, 0, 64'h2222, 1'b1);
        end
        repeat (12) @(posedge clk);
        #1;
        bus.f_req_i = 1'b0; bus.d_req_i = 1'b0;
        drain();

        // Reset during beat 1 of a dword load abandons it.
        @(posedge clk);
        #1;
        bus.d_req_i = 1'b1; bus.d_adr_i = 64'h3000; bus.d_size_i = 2'd3; bus.d_we_i = 1'b0;
        n0 = cyc_n;
        push(K_BEAT, n0 + 1, 64'h3000, 2'd3, 1'b0, 1'b0, 16'h0, 0, 0);
        push(K_BEAT, n0 + 2, 64'h3002, 2'd3, 1'b0, 1'b0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b1; bus.d_req_i = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("midreset_cyc_o", 64'(bus.cyc_o), 64'd0);
        chk("midreset_d_ack_o", 64'(bus.d_ack_o), 64'd0);
        repeat (6) @(posedge clk);
        drain();

        // Recovery: byte fetch at an odd address after the abandoned transaction.
        rd_tab[3] = 16'hBEEF;
        xfer(1'b1, 64'h0007, 2'd0, 1'b0, 64'd0, 64'h0000_0000_0000_00EF, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
